// File: rtl/led_matrix_scan_ctrl_pkg.sv
// Shared types and helpers for the LED matrix scan controller:
// scan state encoding, PWM constants and timer sizing.
package led_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam int unsigned PWM_LEVELS = 16;

  // Lit portion of a dwell window for a 4-bit brightness level.
  function automatic int unsigned on_time(input logic [3:0] level, input int unsigned dwell);
    return ((int'(level) + 1) * dwell) / PWM_LEVELS;
  endfunction

  // Counter width able to hold the longer of the two windows, plus the full-dwell on_time.
  function automatic int timer_width(input int dwell, input int blank);
    return $clog2(((dwell > blank) ? dwell : blank) + 1);
  endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Frame transfer channel: whole-frame pixel word with a valid/ready handshake.
interface led_matrix_scan_ctrl_if #(
  parameter int W = 64
);
  logic [W-1:0] frame_data;
  logic         frame_valid;
  logic         frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_scan_ctrl_dbuf.sv
// Double frame buffer: pending slot filled by the handshake, copied into the
// displayed (active) slot only on the frame-boundary swap strobe.
module led_frame_dbuf
  import led_scan_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  led_matrix_scan_ctrl_if.slave bus,
  input  logic                  swap,
  output logic [W-1:0]          active
);

  logic [W-1:0] pending;
  logic         pending_full;

  assign bus.frame_ready = !pending_full;

  // Accept and swap are mutually exclusive: accept needs an empty slot, swap a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      active       <= '0;
      pending_full <= 1'b0;
    end else if (bus.frame_valid && !pending_full) begin
      pending      <= bus.frame_data;
      pending_full <= 1'b1;
    end else if (swap && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end
  end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-multiplexed LED matrix scanner with per-row blanking, 16-level PWM and a
// tear-free double-buffered frame input. Optional walking-pixel test pattern: LED_SCAN_TESTPAT_EN.
//
// state    | meaning
// ST_BLANK | all rows/columns off for BLANK_CYCLES before each row
// ST_DRIVE | current row selected for DWELL_CYCLES, columns gated by PWM on_time
module led_matrix_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  led_matrix_scan_ctrl_if.slave bus,
  input  logic [3:0]            brightness,
`ifdef LED_SCAN_TESTPAT_EN
  input  logic                  test_mode,
`endif
  output logic [ROWS-1:0]       row_out,
  output logic [COLS-1:0]       col_out,
  output logic                  frame_sync
);

  localparam int TW = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam int RW = $clog2(ROWS);

  scan_state_t          state, state_n;
  logic [TW-1:0]        cnt, cnt_n;
  logic [TW-1:0]        on_q, on_n;
  logic [RW-1:0]        row, row_n;
  logic                 swap;
  logic [ROWS*COLS-1:0] active;
  logic [COLS-1:0]      row_word, disp_word;
  logic [ROWS-1:0]      row_d;
  logic [COLS-1:0]      col_d;
  logic                 sync_d;

  led_frame_dbuf #(.W(ROWS*COLS)) u_dbuf (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .swap   (swap),
    .active (active)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      row   <= '0;
      on_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
      on_q  <= on_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + TW'(1);
    row_n   = row;
    on_n    = on_q;
    swap    = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (cnt == TW'(BLANK_CYCLES - 1)) begin
          state_n = ST_DRIVE;
          cnt_n   = '0;
          on_n    = TW'(on_time(brightness, DWELL_CYCLES));
        end
      end
      ST_DRIVE: begin
        if (cnt == TW'(DWELL_CYCLES - 1)) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          if (row == RW'(ROWS - 1)) begin
            row_n = '0;
            swap  = 1'b1;
          end else begin
            row_n = row + RW'(1);
          end
        end
      end
    endcase
  end

  // Outputs are computed from next-state values so the registered pins line up with the FSM.
  assign sync_d   = (state_n == ST_DRIVE) && (cnt_n == '0) && (row_n == '0);
  assign row_word = COLS'(active >> (row_n * COLS));

`ifdef LED_SCAN_TESTPAT_EN
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          tm_q, tm_n;
  logic [RW-1:0] tp_row, tp_row_n;
  logic [CW-1:0] tp_col, tp_col_n;

  // frame_count is kept as two wrapping indices; they advance with frame_sync so a whole frame is consistent.
  always_comb begin
    tm_n     = (state == ST_BLANK && state_n == ST_DRIVE) ? test_mode : tm_q;
    tp_row_n = tp_row;
    tp_col_n = tp_col;
    if (sync_d) begin
      tp_row_n = (tp_row == RW'(ROWS - 1)) ? '0 : tp_row + RW'(1);
      tp_col_n = (tp_col == CW'(COLS - 1)) ? '0 : tp_col + CW'(1);
    end
    disp_word = row_word;
    if (tm_n) disp_word = (row_n == tp_row_n) ? (COLS'(1) << tp_col_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tm_q   <= 1'b0;
      tp_row <= '0;
      tp_col <= '0;
    end else begin
      tm_q   <= tm_n;
      tp_row <= tp_row_n;
      tp_col <= tp_col_n;
    end
  end
`else
  assign disp_word = row_word;
`endif

  always_comb begin
    row_d = '0;
    col_d = '0;
    if (state_n == ST_DRIVE) begin
      row_d[row_n] = 1'b1;
      if (cnt_n < on_n) col_d = disp_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_out    <= '0;
      col_out    <= '0;
      frame_sync <= 1'b0;
    end else begin
      row_out    <= row_d;
      col_out    <= col_d;
      frame_sync <= sync_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl against a timeline-based reference model.
module tb_led_matrix_scan_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DWELL = 16;
  localparam int BLANK = 2;
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = ROWS * SLOT;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       brightness;
  logic             test_mode;
  logic [ROWS-1:0]  row_out;
  logic [COLS-1:0]  col_out;
  logic             frame_sync;

  led_matrix_scan_ctrl_if #(.W(ROWS*COLS)) bus ();

  led_matrix_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .brightness (brightness),
`ifdef LED_SCAN_TESTPAT_EN
    .test_mode  (test_mode),
`endif
    .row_out    (row_out),
    .col_out    (col_out),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position in the frame timeline plus the two frame slots.
  int              t;
  logic [15:0]     m_active, m_pending;
  bit              m_full, m_acc, m_tm;
  int              m_on, m_fc;
  logic [15:0]     frame_a, frame_b;
  int              guard;

  task automatic model_eoc();
    int p, off;
    m_acc = 1'b0;
    if (reset) begin
      t = 0; m_active = '0; m_pending = '0; m_full = 1'b0;
      m_on = 0; m_tm = 1'b0; m_fc = 0;
      return;
    end
    p = t % FRAME;
    off = p % SLOT;
    if (bus.frame_valid && !m_full) begin
      m_pending = bus.frame_data; m_full = 1'b1; m_acc = 1'b1;
    end else if (p == FRAME - 1 && m_full) begin
      m_active = m_pending; m_full = 1'b0;
    end
    if (off == BLANK - 1) begin
      m_on = ((int'(brightness) + 1) * DWELL) / 16;
      m_tm = test_mode;
    end
    if (p == BLANK - 1) m_fc++;
    t++;
  endtask

  function automatic void exp_outputs(output logic [3:0] r, output logic [3:0] c, output logic s);
    int p, row, k;
    p = t % FRAME; row = p / SLOT; k = (p % SLOT) - BLANK;
    r = '0; c = '0; s = 1'b0;
    if (k >= 0) begin
      r = 4'(1 << row);
      s = (row == 0 && k == 0);
      if (k < m_on) begin
        if (m_tm) c = (row == m_fc % ROWS) ? 4'(1 << (m_fc % COLS)) : 4'h0;
        else      c = 4'(m_active >> (row * COLS));
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] er, ec;
    logic       es;
    model_eoc();
    @(posedge clk);
    #1;
    exp_outputs(er, ec, es);
    check("row_out", 32'(row_out), 32'(er));
    check("col_out", 32'(col_out), 32'(ec));
    check("frame_sync", 32'(frame_sync), 32'(es));
    check("frame_ready", 32'(bus.frame_ready), 32'(!m_full));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; brightness = 4'd0; test_mode = 1'b0;
    bus.frame_valid = 1'b0; bus.frame_data = '0;
    run(3);
    reset = 1'b0;

    // Idle scan: no frame offered, columns stay dark.
    run(2 * FRAME);

    // Directed frame at full brightness.
    brightness = 4'd15;
    bus.frame_data = 16'hA5C3; bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    run(2 * FRAME);

    brightness = 4'd0;
    run(FRAME + 10);
    brightness = 4'd7;
    run(FRAME);
    brightness = 4'd15;

    // Two frames back to back offered mid-frame; the second stalls until the swap.
    run(25);
    frame_a = 16'h1E69; frame_b = 16'hF00F;
    bus.frame_data = frame_a; bus.frame_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (m_acc && bus.frame_data == frame_a) bus.frame_data = frame_b;
      else if (m_acc) bus.frame_valid = 1'b0;
    end
    bus.frame_valid = 1'b0;

    // Randomized brightness and frame offers, including mid-row brightness changes.
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 19) == 0) brightness = 4'($urandom_range(0, 15));
      if (!bus.frame_valid && $urandom_range(0, 29) == 0) begin
        bus.frame_data = 16'($urandom); bus.frame_valid = 1'b1;
      end else if (bus.frame_valid && $urandom_range(0, 3) == 0) begin
        bus.frame_valid = 1'b0;
      end
      tick();
      if (m_acc) bus.frame_valid = 1'b0;
    end
    bus.frame_valid = 1'b0;

    // Reset during row 2 DRIVE; pending data is offered first so it must be lost.
    bus.frame_data = 16'h7777; bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    guard = 0;
    while (!((t % FRAME) / SLOT == 2 && (t % SLOT) >= BLANK + 3) && guard < 2 * FRAME) begin
      tick(); guard++;
    end
    check("reach_row2", 32'(guard < 2 * FRAME), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(FRAME + 20);

`ifdef LED_SCAN_TESTPAT_EN
    bus.frame_data = 16'hBEEF; bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    brightness = 4'd15;
    test_mode = 1'b1;
    run(5 * FRAME + 7);
    test_mode = 1'b0;
    run(2 * FRAME);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
